// File: rtl/divconv_ctrl_if.sv
// rtl/divconv_ctrl_if.sv - issue/datapath handshake bundle for the divconv sequencing controller
interface divconv_ctrl_if;
    logic       start;
    logic       op_type_in;
    logic       P_in;
    logic       op_type;
    logic       P;
    logic [2:0] sel_muxa;
    logic [2:0] sel_muxb;
    logic       sel_muxr;
    logic       load_rega;
    logic       load_regb;
    logic       load_regc;
    logic       load_regd;
    logic       load_regr;
    logic       load_regs;
    logic       busy;
    logic       done;

    modport master (
        input  start, op_type_in, P_in,
        output op_type, P, sel_muxa, sel_muxb, sel_muxr,
               load_rega, load_regb, load_regc, load_regd, load_regr, load_regs,
               busy, done
    );

    modport slave (
        output start, op_type_in, P_in,
        input  op_type, P, sel_muxa, sel_muxb, sel_muxr,
               load_rega, load_regb, load_regc, load_regd, load_regr, load_regs,
               busy, done
    );
endinterface

// File: rtl/divconv_ctrl.sv
// rtl/divconv_ctrl.sv - Goldschmidt divide/sqrt sequencer; remainder step enabled by DIVCONV_CTRL_REM_EN
module divconv_ctrl #(
    parameter int ITER_SP = 2,
    parameter int ITER_DP = 3,
    parameter int CNT_W   = 3
) (
    input  logic                clk,
    input  logic                reset,
    divconv_ctrl_if.master      bus
);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_PRE0 = 4'd1,
        ST_PRE1 = 4'd2,
        ST_PRE2 = 4'd3,
        ST_ITN  = 4'd4,
        ST_ITD  = 4'd5,
        ST_SQK  = 4'd6,
        ST_SQD  = 4'd7,
        ST_SQN  = 4'd8,
        ST_RND  = 4'd9,
        ST_REM  = 4'd10,
        ST_DONE = 4'd11
    } state_t;

    localparam logic [CNT_W-1:0] SP_LAST = CNT_W'(ITER_SP - 1);
    localparam logic [CNT_W-1:0] DP_LAST = CNT_W'(ITER_DP - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             op_type_q;
    logic             p_q;
    logic             iter_end;
    logic             last_iter;

    // An iteration ends on ITD for divide and on SQN for sqrt; the count only moves there.
    assign iter_end  = (state == ST_ITD) || (state == ST_SQN);
    assign last_iter = (cnt == (p_q ? SP_LAST : DP_LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op_type_q <= 1'b0;
            p_q       <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && bus.start) begin
                op_type_q <= bus.op_type_in;
                p_q       <= bus.P_in;
            end
            if (iter_end) begin
                cnt <= last_iter ? '0 : cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (bus.start) state_next = ST_PRE0;
            ST_PRE0: state_next = ST_PRE1;
            ST_PRE1: state_next = op_type_q ? ST_PRE2 : ST_ITN;
            ST_PRE2: state_next = ST_SQK;
            ST_ITN:  state_next = ST_ITD;
            ST_ITD:  state_next = last_iter ? ST_RND : ST_ITN;
            ST_SQK:  state_next = ST_SQD;
            ST_SQD:  state_next = ST_SQN;
            ST_SQN:  state_next = last_iter ? ST_RND : ST_SQK;
`ifdef DIVCONV_CTRL_REM_EN
            ST_RND:  state_next = ST_REM;
`else
            ST_RND:  state_next = ST_DONE;
`endif
            ST_REM:  state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.sel_muxa  = 3'd0;
        bus.sel_muxb  = 3'd0;
        bus.sel_muxr  = 1'b0;
        bus.load_rega = 1'b0;
        bus.load_regb = 1'b0;
        bus.load_regc = 1'b0;
        bus.load_regd = 1'b0;
        bus.load_regr = 1'b0;
        bus.load_regs = 1'b0;
        bus.busy      = (state != ST_IDLE);
        bus.done      = 1'b0;
        unique case (state)
            ST_PRE0: begin
                // Divide forms D*K0; sqrt forms K0^2 into regd.
                bus.sel_muxa = 3'd2;
                if (op_type_q) begin
                    bus.sel_muxb  = 3'd1;
                    bus.load_regd = 1'b1;
                end else begin
                    bus.sel_muxb  = 3'd0;
                    bus.load_rega = 1'b1;
                    bus.load_regc = 1'b1;
                end
            end
            ST_PRE1: begin
                if (op_type_q) begin
                    bus.sel_muxa  = 3'd4;
                    bus.sel_muxb  = 3'd0;
                    bus.load_rega = 1'b1;
                    bus.load_regc = 1'b1;
                end else begin
                    bus.sel_muxa  = 3'd1;
                    bus.sel_muxb  = 3'd1;
                    bus.load_regb = 1'b1;
                end
            end
            ST_PRE2: begin
                bus.sel_muxa  = 3'd1;
                bus.sel_muxb  = 3'd1;
                bus.load_regb = 1'b1;
            end
            ST_ITN: begin
                bus.sel_muxb  = 3'd6;
                bus.load_regb = 1'b1;
            end
            ST_ITD: begin
                bus.sel_muxb  = 3'd2;
                bus.load_rega = 1'b1;
                bus.load_regc = 1'b1;
            end
            ST_SQK: begin
                bus.sel_muxb  = 3'd3;
                bus.load_regd = 1'b1;
            end
            ST_SQD: begin
                bus.sel_muxa  = 3'd4;
                bus.sel_muxb  = 3'd2;
                bus.load_rega = 1'b1;
                bus.load_regc = 1'b1;
            end
            ST_SQN: begin
                bus.sel_muxb  = 3'd6;
                bus.load_regb = 1'b1;
            end
            ST_RND: begin
                bus.load_regs = 1'b1;
            end
`ifdef DIVCONV_CTRL_REM_EN
            ST_REM: begin
                bus.sel_muxr  = 1'b1;
                bus.load_regr = 1'b1;
            end
`else
            ST_REM: begin
            end
`endif
            ST_DONE: begin
                bus.done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.op_type = op_type_q;
    assign bus.P       = p_q;

endmodule

// File: tb/tb_divconv_ctrl.sv
// tb/tb_divconv_ctrl.sv - directed bench for divconv_ctrl sequencing and latency
module tb_divconv_ctrl;

    logic clk;
    logic reset;
    divconv_ctrl_if bus();

    divconv_ctrl #(.ITER_SP(2), .ITER_DP(3), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DIVCONV_CTRL_REM_EN
    localparam bit REM_ON = 1'b1;
    localparam int L_DIV_DP = 11;
    localparam int B2B_SECOND = 19;
`else
    localparam bit REM_ON = 1'b0;
    localparam int L_DIV_DP = 10;
    localparam int B2B_SECOND = 17;
`endif
    localparam int L_DIV_SP = L_DIV_DP - 2;

    localparam logic [5:0] LA = 6'b100000;
    localparam logic [5:0] LB = 6'b010000;
    localparam logic [5:0] LC = 6'b001000;
    localparam logic [5:0] LD = 6'b000100;
    localparam logic [5:0] LR = 6'b000010;
    localparam logic [5:0] LS = 6'b000001;

    int total;
    int bad;
    logic [14:0] exp_q[$];
    logic [31:0] regb_m, regc_m, regs_m, regr_m, done_m;

    function automatic logic [14:0] mk(input logic [2:0] a, input logic [2:0] b, input logic m,
                                       input logic [5:0] ld, input logic bsy, input logic dn);
        return {a, b, m, ld, bsy, dn};
    endfunction

    function automatic logic [14:0] obs();
        return {bus.sel_muxa, bus.sel_muxb, bus.sel_muxr, bus.load_rega, bus.load_regb,
                bus.load_regc, bus.load_regd, bus.load_regr, bus.load_regs, bus.busy, bus.done};
    endfunction

    task automatic build(input logic op, input logic p);
        int n;
        n = p ? 2 : 3;
        exp_q = {};
        if (!op) begin
            exp_q.push_back(mk(3'd2, 3'd0, 1'b0, LA | LC, 1'b1, 1'b0));
            exp_q.push_back(mk(3'd1, 3'd1, 1'b0, LB, 1'b1, 1'b0));
            for (int i = 0; i < n; i++) begin
                exp_q.push_back(mk(3'd0, 3'd6, 1'b0, LB, 1'b1, 1'b0));
                exp_q.push_back(mk(3'd0, 3'd2, 1'b0, LA | LC, 1'b1, 1'b0));
            end
        end else begin
            exp_q.push_back(mk(3'd2, 3'd1, 1'b0, LD, 1'b1, 1'b0));
            exp_q.push_back(mk(3'd4, 3'd0, 1'b0, LA | LC, 1'b1, 1'b0));
            exp_q.push_back(mk(3'd1, 3'd1, 1'b0, LB, 1'b1, 1'b0));
            for (int i = 0; i < n; i++) begin
                exp_q.push_back(mk(3'd0, 3'd3, 1'b0, LD, 1'b1, 1'b0));
                exp_q.push_back(mk(3'd4, 3'd2, 1'b0, LA | LC, 1'b1, 1'b0));
                exp_q.push_back(mk(3'd0, 3'd6, 1'b0, LB, 1'b1, 1'b0));
            end
        end
        exp_q.push_back(mk(3'd0, 3'd0, 1'b0, LS, 1'b1, 1'b0));
        if (REM_ON) exp_q.push_back(mk(3'd0, 3'd0, 1'b1, LR, 1'b1, 1'b0));
        exp_q.push_back(mk(3'd0, 3'd0, 1'b0, 6'd0, 1'b1, 1'b1));
    endtask

    // Starts an op at edge 0 and checks cycles 1..L plus the following idle cycle.
    task automatic run_op(input logic op, input logic p, input logic [31:0] pulse, input string name);
        int L;
        logic [14:0] e;
        build(op, p);
        L = exp_q.size();
        regb_m = 0; regc_m = 0; regs_m = 0; regr_m = 0; done_m = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.op_type_in = op; bus.P_in = p;
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (pulse != 0) begin
            bus.op_type_in = ~op; bus.P_in = ~p;
        end
        for (int c = 1; c <= L + 1; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            bus.start = pulse[c];
            @(negedge clk);
            e = (c <= L) ? exp_q[c-1] : 15'd0;
            if (bus.load_regb) regb_m[c] = 1'b1;
            if (bus.load_regc) regc_m[c] = 1'b1;
            if (bus.load_regs) regs_m[c] = 1'b1;
            if (bus.load_regr && bus.sel_muxr) regr_m[c] = 1'b1;
            if (bus.done) done_m[c] = 1'b1;
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL %s cycle %0d outputs got=%h want=%h", name, c, obs(), e);
            end
            if (c <= L) begin
                total++;
                if ({bus.op_type, bus.P} !== {op, p}) begin
                    bad++;
                    $display("FAIL %s cycle %0d latched op/P got=%b%b want=%b%b",
                             name, c, bus.op_type, bus.P, op, p);
                end
            end
        end
        bus.start = 1'b0; bus.op_type_in = 1'b0; bus.P_in = 1'b0;
    endtask

    task automatic test_reset();
        int dn;
        reset = 1'b1;
        bus.start = 1'b1; bus.op_type_in = 1'b1; bus.P_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({obs(), bus.op_type, bus.P} !== 17'd0) begin
            bad++;
            $display("FAIL reset_state got=%h want=0", {obs(), bus.op_type, bus.P});
        end
        bus.start = 1'b0; bus.op_type_in = 1'b0; bus.P_in = 1'b0;
        reset = 1'b0;
        // Abort a div DP op while it sits in ITD (cycle 4).
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        total++;
        if (obs() !== mk(3'd0, 3'd2, 1'b0, LA | LC, 1'b1, 1'b0)) begin
            bad++;
            $display("FAIL reset_mid_itd pre got=%h want=%h", obs(), mk(3'd0, 3'd2, 1'b0, LA | LC, 1'b1, 1'b0));
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (obs() !== 15'd0) begin
            bad++;
            $display("FAIL reset_abort got=%h want=0", obs());
        end
        dn = 0;
        repeat (14) begin
            @(negedge clk);
            if (bus.done || bus.busy) dn++;
        end
        total++;
        if (dn !== 0) begin
            bad++;
            $display("FAIL reset_no_done got=%0d want=0", dn);
        end
    endtask

    task automatic test_div_dp();
        run_op(1'b0, 1'b0, 32'd0, "div_dp");
        total++;
        if (regb_m !== 32'h0000_00ac) begin
            bad++; $display("FAIL div_dp_regb got=%h want=000000ac", regb_m);
        end
        total++;
        if (regc_m !== 32'h0000_0152) begin
            bad++; $display("FAIL div_dp_regc got=%h want=00000152", regc_m);
        end
        total++;
        if (regs_m !== 32'h0000_0200) begin
            bad++; $display("FAIL div_dp_regs got=%h want=00000200", regs_m);
        end
        total++;
        if (regr_m !== (REM_ON ? 32'h0000_0400 : 32'h0)) begin
            bad++; $display("FAIL div_dp_regr got=%h want=%h", regr_m, REM_ON ? 32'h400 : 32'h0);
        end
        total++;
        if (done_m !== (32'd1 << L_DIV_DP)) begin
            bad++; $display("FAIL div_dp_done got=%h want=%h", done_m, 32'd1 << L_DIV_DP);
        end
    endtask

    task automatic test_div_sp();
        run_op(1'b0, 1'b1, 32'd0, "div_sp");
        total++;
        if (done_m !== (32'd1 << L_DIV_SP)) begin
            bad++; $display("FAIL div_sp_done got=%h want=%h", done_m, 32'd1 << L_DIV_SP);
        end
    endtask

    task automatic test_sqrt_sp();
        run_op(1'b1, 1'b1, 32'd0, "sqrt_sp");
        total++;
        if (done_m !== (32'd1 << (REM_ON ? 12 : 11))) begin
            bad++; $display("FAIL sqrt_sp_done got=%h want=%h", done_m, 32'd1 << (REM_ON ? 12 : 11));
        end
    endtask

    task automatic test_sqrt_dp();
        run_op(1'b1, 1'b0, 32'd0, "sqrt_dp");
        total++;
        if (done_m !== (32'd1 << (REM_ON ? 15 : 14))) begin
            bad++; $display("FAIL sqrt_dp_done got=%h want=%h", done_m, 32'd1 << (REM_ON ? 15 : 14));
        end
    endtask

    task automatic test_ignore_start();
        run_op(1'b0, 1'b0, (32'd1 << 3) | (32'd1 << L_DIV_DP), "ignore_start");
        total++;
        if (done_m !== (32'd1 << L_DIV_DP)) begin
            bad++; $display("FAIL ignore_start_done got=%h want=%h", done_m, 32'd1 << L_DIV_DP);
        end
    endtask

    task automatic test_back_to_back();
        int first, second, cnt, guard;
        first = 0; second = 0; cnt = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.op_type_in = 1'b0; bus.P_in = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.done) begin
                cnt++;
                if (cnt == 1) first = c;
                if (cnt == 2) second = c;
            end
        end
        bus.start = 1'b0;
        total++;
        if (first !== L_DIV_SP || second !== B2B_SECOND || cnt !== 2) begin
            bad++;
            $display("FAIL back_to_back got=%0d,%0d n=%0d want=%0d,%0d n=2",
                     first, second, cnt, L_DIV_SP, B2B_SECOND);
        end
        guard = 0;
        while (bus.busy && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL back_to_back_drain busy got=%b want=0", bus.busy);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.op_type_in = 1'b0; bus.P_in = 1'b0;
        test_reset();
        test_div_dp();
        test_div_sp();
        test_sqrt_sp();
        test_sqrt_dp();
        test_ignore_start();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
